relu8_pack_wr: RTL and testbench

RELU8_PACK_WR -- requirements
Module: relu8_pack_wr

---
 rtl/relu8_pack_wr.sv | 173 +++++++++++++++++
 tb/tb_relu8_pack_wr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/relu8_pack_wr.sv
// relu8_pack_wr -- packs 8-lane ReLU output beats into 32-bit words and
// writes them sequentially into a feature RAM.
//
// Ports:
//   clk_cal, rst_n             clock (rising edge), async active-low reset
//   start, base_addr, word_num job launch: first address and word count
//   Relu_Dout1..8, _vld1..8    one byte per lane with per-lane valid
//   in_ready                   an 8-byte beat can be taken this cycle
//   mem_wr_en/addr/wdata       write request toward the RAM
//   mem_wr_ready               RAM accepts the request this cycle
//   busy, done, lane_err       job status; lane_err is sticky until next start
module relu8_pack_wr #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_cal,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_num,
  input  logic [7:0]        Relu_Dout1,
  input  logic [7:0]        Relu_Dout2,
  input  logic [7:0]        Relu_Dout3,
  input  logic [7:0]        Relu_Dout4,
  input  logic [7:0]        Relu_Dout5,
  input  logic [7:0]        Relu_Dout6,
  input  logic [7:0]        Relu_Dout7,
  input  logic [7:0]        Relu_Dout8,
  input  logic              Relu_Dout_vld1,
  input  logic              Relu_Dout_vld2,
  input  logic              Relu_Dout_vld3,
  input  logic              Relu_Dout_vld4,
  input  logic              Relu_Dout_vld5,
  input  logic              Relu_Dout_vld6,
  input  logic              Relu_Dout_vld7,
  input  logic              Relu_Dout_vld8,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              lane_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Occupancy at or below this leaves room for a full two-word beat.
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wnum_q, wnum_d;
  logic [ADDR_W-1:0]   push_left_q, push_left_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic                lane_err_q, lane_err_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         fifo_q [FIFO_DEPTH];

  logic [7:0]          vld_vec;
  logic                vld_all, vld_any;
  logic                accept, push2, pop;
  logic [CNT_W-1:0]    push_n, pop_n;
  logic [31:0]         word0, word1;

  assign vld_vec = {Relu_Dout_vld8, Relu_Dout_vld7, Relu_Dout_vld6, Relu_Dout_vld5,
                    Relu_Dout_vld4, Relu_Dout_vld3, Relu_Dout_vld2, Relu_Dout_vld1};
  assign vld_all = &vld_vec;
  assign vld_any = |vld_vec;
  assign word0   = {Relu_Dout4, Relu_Dout3, Relu_Dout2, Relu_Dout1};
  assign word1   = {Relu_Dout8, Relu_Dout7, Relu_Dout6, Relu_Dout5};

  assign in_ready  = (state_q == S_RUN) && (count_q <= CNT_LIM) && (push_left_q != '0);
  assign accept    = in_ready && vld_all;
  // Upper word is only stored when at least two words are still owed.
  assign push2     = accept && (push_left_q > ADDR_W'(1));
  assign mem_wr_en = (state_q == S_RUN) && (count_q != '0);
  assign pop       = mem_wr_en && mem_wr_ready;
  assign push_n    = accept ? (push2 ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign pop_n     = pop ? CNT_W'(1) : '0;

  assign mem_addr  = addr_q;
  // Gated by occupancy so the unreset storage never leaks onto the bus.
  assign mem_wdata = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign lane_err  = lane_err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wnum_d      = wnum_q;
    push_left_d = push_left_q;
    wr_cnt_d    = wr_cnt_q;
    lane_err_d  = lane_err_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          wnum_d      = word_num;
          push_left_d = word_num;
          wr_cnt_d    = '0;
          lane_err_d  = 1'b0;
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
          count_d     = '0;
          state_d     = (word_num == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (vld_any && !vld_all) lane_err_d = 1'b1;
        if (accept) begin
          if (push2) begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(2);
            push_left_d = push_left_q - ADDR_W'(2);
          end else begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            push_left_d = push_left_q - ADDR_W'(1);
          end
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          addr_d   = addr_q + ADDR_W'(1);
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          if ((wr_cnt_q + ADDR_W'(1)) == wnum_q) state_d = S_DONE;
        end
        count_d = count_q + push_n - pop_n;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cal or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wnum_q      <= '0;
      push_left_q <= '0;
      wr_cnt_q    <= '0;
      lane_err_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wnum_q      <= wnum_d;
      push_left_q <= push_left_d;
      wr_cnt_q    <= wr_cnt_d;
      lane_err_q  <= lane_err_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_cal) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= word0;
      if (push2) fifo_q[wr_ptr_q + PTR_W'(1)] <= word1;
    end
  end

endmodule

// File: tb/tb_relu8_pack_wr.sv
module tb_relu8_pack_wr;

  logic        clk_cal = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr, word_num;
  logic [7:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0]  vld;
  logic        in_ready, mem_wr_en, mem_wr_ready, busy, done, lane_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  logic [43:0] exp_q [$];
  logic [11:0] exp_addr;
  int          exp_left;

  relu8_pack_wr #(.ADDR_W(12), .FIFO_DEPTH(4)) dut (
    .clk_cal(clk_cal), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .word_num(word_num),
    .Relu_Dout1(d1), .Relu_Dout2(d2), .Relu_Dout3(d3), .Relu_Dout4(d4),
    .Relu_Dout5(d5), .Relu_Dout6(d6), .Relu_Dout7(d7), .Relu_Dout8(d8),
    .Relu_Dout_vld1(vld[0]), .Relu_Dout_vld2(vld[1]), .Relu_Dout_vld3(vld[2]),
    .Relu_Dout_vld4(vld[3]), .Relu_Dout_vld5(vld[4]), .Relu_Dout_vld6(vld[5]),
    .Relu_Dout_vld7(vld[6]), .Relu_Dout_vld8(vld[7]),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr_ready(mem_wr_ready),
    .busy(busy), .done(done), .lane_err(lane_err)
  );

  always #5 clk_cal = ~clk_cal;
  always @(posedge clk_cal) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write handshake pops and compares one expected word.
  always @(negedge clk_cal) begin
    if (rst_n === 1'b1 && mem_wr_en && mem_wr_ready) begin
      wr_count++;
      last_wr_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
               mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        logic [43:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {52'd0, mem_addr}, {52'd0, e[43:32]});
        chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk_cal);
    #1;
  endtask

  task automatic set_lanes(input logic [7:0] b, input logic [7:0] v);
    d1 = b; d2 = b + 8'd1; d3 = b + 8'd2; d4 = b + 8'd3;
    d5 = b + 8'd4; d6 = b + 8'd5; d7 = b + 8'd6; d8 = b + 8'd7;
    vld = v;
  endtask

  task automatic start_job(input logic [11:0] ba, input logic [11:0] wn);
    base_addr = ba; word_num = wn; start = 1'b1;
    exp_addr = ba; exp_left = int'(wn);
    tick();
    start = 1'b0;
  endtask

  // Present a full beat, wait (bounded) for in_ready, predict its words.
  task automatic send_beat(input logic [7:0] b);
    int n;
    set_lanes(b, 8'hFF);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("beat_in_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) begin
      exp_q.push_back({exp_addr, b + 8'd3, b + 8'd2, b + 8'd1, b});
      exp_addr++; exp_left--;
      if (exp_left > 0) begin
        exp_q.push_back({exp_addr, b + 8'd7, b + 8'd6, b + 8'd5, b + 8'd4});
        exp_addr++; exp_left--;
      end
    end
    tick();
    vld = 8'h00;
  endtask

  task automatic wait_done(input bit chk_timing);
    int n;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    if (chk_timing) chk("done_after_last_wr", 64'(cyc), 64'(last_wr_cyc + 1));
    tick();
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {18'd0, in_ready, mem_wr_en, mem_addr, mem_wdata, busy, done, lane_err}, 64'd0);
  endtask

  initial begin
    int w0;
    logic [11:0] ha;
    logic [31:0] hd;
    rst_n = 1'b1; start = 1'b0; base_addr = '0; word_num = '0;
    mem_wr_ready = 1'b0; set_lanes(8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_outputs");
    tick(); tick();
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    tick();

    // Two full beats, four words, RAM always ready.
    mem_wr_ready = 1'b1;
    w0 = wr_count;
    start_job(12'h010, 12'd4);
    chk("run_busy", {62'd0, busy, in_ready}, 64'd3);
    send_beat(8'h01);
    chk("latency_wr_en", {63'd0, mem_wr_en}, 64'd1);
    chk("latency_word0", {32'd0, mem_wdata}, 64'h04030201);
    chk("latency_addr", {52'd0, mem_addr}, 64'h010);
    send_beat(8'h11);
    wait_done(1'b1);
    chk("job1_writes", 64'(wr_count - w0), 64'd4);

    // Odd word count: second beat's upper word is discarded.
    w0 = wr_count;
    start_job(12'h100, 12'd3);
    send_beat(8'h21);
    send_beat(8'h31);
    chk("odd_in_ready_off", {63'd0, in_ready}, 64'd0);
    wait_done(1'b1);
    chk("job2_writes", 64'(wr_count - w0), 64'd3);

    // Backpressure with address wrap past all-ones.
    mem_wr_ready = 1'b0;
    start_job(12'hFFF, 12'd2);
    send_beat(8'h41);
    chk("bp_wr_en", {63'd0, mem_wr_en}, 64'd1);
    ha = mem_addr; hd = mem_wdata;
    chk("bp_addr_first", {52'd0, ha}, 64'hFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {19'd0, mem_wr_en, mem_addr, mem_wdata}, {19'd0, 1'b1, ha, hd});
    end
    mem_wr_ready = 1'b1;
    wait_done(1'b1);

    // Lane valid disagreement: dropped beat, sticky error.
    w0 = wr_count;
    start_job(12'h200, 12'd2);
    set_lanes(8'h99, 8'h7F);
    tick();
    vld = 8'h00;
    chk("lane_err_set", {63'd0, lane_err}, 64'd1);
    chk("lane_no_push", {63'd0, mem_wr_en}, 64'd0);
    send_beat(8'h51);
    wait_done(1'b1);
    chk("lane_err_sticky", {63'd0, lane_err}, 64'd1);
    chk("lane_job_writes", 64'(wr_count - w0), 64'd2);

    // Zero-length job: one cycle busy with done, no writes; clears lane_err.
    w0 = wr_count;
    start_job(12'h0AB, 12'd0);
    chk("zero_done", {61'd0, busy, done, lane_err}, 64'd6);
    tick();
    chk("zero_idle", {62'd0, busy, done}, 64'd0);
    chk("zero_writes", 64'(wr_count - w0), 64'd0);

    // A start during RUN must be ignored.
    mem_wr_ready = 1'b0;
    start_job(12'h300, 12'd2);
    base_addr = 12'h555; word_num = 12'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_busy", {62'd0, busy, done}, 64'd2);
    mem_wr_ready = 1'b1;
    send_beat(8'h61);
    wait_done(1'b1);

    // Reset while two words sit in the FIFO behind a stalled RAM.
    mem_wr_ready = 1'b0;
    start_job(12'h400, 12'd4);
    send_beat(8'h71);
    chk("pre_rst_pending", {63'd0, mem_wr_en}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset_outputs");
    exp_q.delete();
    w0 = wr_count;
    tick();
    rst_n = 1'b1;
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_no_writes", 64'(wr_count - w0), 64'd0);
    chk("post_rst_idle", {62'd0, busy, mem_wr_en}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
